// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM states and sign helper for the iterative mul/div unit.
package md_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
    OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} md_state_e;
  function automatic logic md_is_signed(md_op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: bit-serial datapath, shift-add multiply or restoring divide on {upper, lower} accumulator.
module md_iter_core #(parameter int WIDTH = 32) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          run,
  input  logic                          is_div,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  output logic [2*WIDTH-1:0]            acc,
  output logic [$clog2(WIDTH+1)-1:0]    cnt
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  logic [W2-1:0] acc_q, acc_d, mul_next, div_next;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_d    = load ? {{WIDTH{1'b0}}, a_in} : run ? (is_div ? div_next : mul_next) : acc_q;
    b_d      = load ? b_in : b_q;
    cnt_d    = load ? CW'(WIDTH) : run ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end
  assign acc = acc_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide/MAC unit with HI/LO registers, divide-by-zero flag and flush cancel.
module md_iter_unit import md_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             div_zero
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  md_state_e state_q, state_d;
  md_op_e op_q, op_d, op_in;
  logic sa_q, sa_d, sb_q, sb_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic [W2-1:0] acc, prod, hilo, mac;
  logic [CW-1:0] cnt;
  logic idle, is_div, go, fix_wr, div_op_q;
  always_comb begin
    op_in      = md_op_e'(op);
    idle       = state_q == ST_IDLE;
    is_div     = op_in inside {OP_DIV, OP_DIVU};
    go         = idle && start && !(is_div && src_b == '0) &&
                 op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    a_mag      = (md_is_signed(op_in) && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag      = (md_is_signed(op_in) && src_b[WIDTH-1]) ? -src_b : src_b;
    state_d    = (cancel && !idle) ? ST_IDLE : go ? ST_CALC :
                 (state_q == ST_CALC && cnt == CW'(1)) ? ST_FIX :
                 (state_q == ST_FIX) ? ST_IDLE : state_q;
    op_d       = go ? op_in : op_q;
    sa_d       = go ? md_is_signed(op_in) && src_a[WIDTH-1] : sa_q;
    sb_d       = go ? md_is_signed(op_in) && src_b[WIDTH-1] : sb_q;
    div_zero_d = idle && start && is_div && src_b == '0;
    // magnitudes were computed bit-serially; restore signs here
    prod       = (sa_q ^ sb_q) ? -acc : acc;
    hilo       = {hi_q, lo_q};
    mac        = (op_q inside {OP_MADD, OP_MADDU}) ? hilo + prod :
                 (op_q inside {OP_MSUB, OP_MSUBU}) ? hilo - prod : prod;
    quo        = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem        = sa_q ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    div_op_q   = op_q inside {OP_DIV, OP_DIVU};
    fix_wr     = state_q == ST_FIX && !cancel;
    hi_d       = fix_wr ? (div_op_q ? rem : mac[W2-1:WIDTH]) :
                 (idle && start && op_in == OP_MTHI) ? src_a : hi_q;
    lo_d       = fix_wr ? (div_op_q ? quo : mac[WIDTH-1:0]) :
                 (idle && start && op_in == OP_MTLO) ? src_a : lo_q;
    res        = (!start && idle) ? (op_in == OP_MFHI ? hi_q : op_in == OP_MFLO ? lo_q : '0) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end
  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (go),
    .run    (state_q == ST_CALC),
    .is_div (div_op_q),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (acc),
    .cnt    (cnt)
  );
  assign busy     = !idle;
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: directed self-checking bench for md_iter_unit at WIDTH=32.
module tb_md_iter_unit;
  import md_pkg::*;
  logic clk = 0, reset = 0, start = 0, cancel = 0;
  logic [3:0] op = 4'd0;
  logic [31:0] src_a = 0, src_b = 0, res;
  logic busy, div_zero;
  int checks = 0, errors = 0;
  md_iter_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .res(res), .busy(busy), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk); op = o; src_a = a; src_b = b; start = 1;
    @(negedge clk); start = 0; op = OP_NOP;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
  endtask
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    op = OP_MFHI; #1 h = res;
    op = OP_MFLO; #1 l = res;
    op = OP_NOP;
  endtask
  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1; repeat (2) @(negedge clk); reset = 0;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
    checks++; if ({h, l} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {h, l}); end
  endtask
  task automatic test_mult;
    logic [31:0] h, l; int cyc;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, cyc);
    read_hilo(h, l);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", cyc); end
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFE) begin errors++; $display("FAIL mult got %h want FFFFFFFFFFFFFFFE", {h, l}); end
    @(negedge clk); op = OP_MFHI; start = 1; #1;
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL res_gated_start got %h want 0", res); end
    start = 0; op = OP_NOP;
  endtask
  task automatic test_div;
    logic [31:0] h, l; int cyc;
    run_op(OP_DIVU, 32'd100, 32'd7, cyc); read_hilo(h, l);
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu got %h want 000000020000000e", {h, l}); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got %h want FFFFFFFFFFFFFFFD", {h, l}); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_minint got %h want 0000000080000000", {h, l}); end
  endtask
  task automatic test_mac;
    logic [31:0] h, l; int cyc;
    @(negedge clk); op = OP_MTHI; src_a = 32'd5; start = 1;
    @(negedge clk); op = OP_MTLO; src_a = 32'hFFFFFFFF;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    @(negedge clk); start = 0; op = OP_NOP;
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL mthi_mtlo got %h want 00000005FFFFFFFF", {h, l}); end
    run_op(OP_MADDU, 32'd1, 32'd1, cyc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000006_00000000) begin errors++; $display("FAIL maddu got %h want 0000000600000000", {h, l}); end
    run_op(OP_MSUB, 32'd1, 32'd1, cyc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL msub got %h want 00000005FFFFFFFF", {h, l}); end
  endtask
  task automatic test_div_zero;
    logic [31:0] h, l;
    @(negedge clk); op = OP_MTHI; src_a = 32'h1234; start = 1;
    @(negedge clk); op = OP_MTLO;
    @(negedge clk); op = OP_DIV; src_a = 32'd9; src_b = 32'd0;
    @(negedge clk); start = 0; op = OP_NOP;
    checks++; if ({div_zero, busy} !== 2'b10) begin errors++; $display("FAIL dz_pulse got dz/busy %b want 10", {div_zero, busy}); end
    @(negedge clk);
    checks++; if ({div_zero, busy} !== 2'b00) begin errors++; $display("FAIL dz_clear got dz/busy %b want 00", {div_zero, busy}); end
    read_hilo(h, l);
    checks++; if ({h, l} !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL dz_hilo got %h want 0000123400001234", {h, l}); end
  endtask
  task automatic test_cancel;
    logic [31:0] h, l; int cyc;
    @(negedge clk); op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1;
    @(negedge clk); start = 0; op = OP_NOP;
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk); cancel = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy); end
    read_hilo(h, l);
    checks++; if ({h, l} !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL cancel_hilo got %h want 0000123400001234", {h, l}); end
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1;
    @(negedge clk); start = 0; op = OP_NOP;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'd12) begin errors++; $display("FAIL restart got %h want 000000000000000c", {h, l}); end
    @(negedge clk); op = OP_MTLO; src_a = 32'h77; start = 1; cancel = 1;
    @(negedge clk); start = 0; cancel = 0; op = OP_NOP;
    read_hilo(h, l);
    checks++; if (l !== 32'h77) begin errors++; $display("FAIL idle_cancel_mtlo got %h want 00000077", l); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] h, l; int cyc;
    @(negedge clk); op = OP_DIVU; src_a = 32'd1000; src_b = 32'd10; start = 1;
    @(negedge clk); op = OP_MTHI; src_a = 32'hDEAD; start = 1;
    @(negedge clk); op = OP_MULTU; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk); start = 0; op = OP_NOP;
    cyc = 3;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    read_hilo(h, l);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_cycles got %0d want 34", cyc); end
    checks++; if ({h, l} !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_result got %h want 0000000000000064", {h, l}); end
    run_op(OP_NOP, 0, 0, cyc);
    @(negedge clk); op = OP_DIVU; src_a = 32'd50; src_b = 32'd3; start = 1;
    @(negedge clk); start = 0; op = OP_NOP;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk); reset = 0;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if ({h, l} !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h want 0", {h, l}); end
    repeat (40) @(negedge clk);
    read_hilo(h, l);
    checks++; if ({busy, h, l} !== 65'd0) begin errors++; $display("FAIL midreset_stays got %h want 0", {busy, h, l}); end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mac;
    test_div_zero;
    test_cancel;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised iterative multiply/divide unit for the EX stage, succeeding the fixed-latency behavioural HI/LO unit. It computes products and quotients bit-serially (radix-2 shift-add multiply, restoring divide) over a configurable operand width. It adds multiply-accumulate ops, a divide-by-zero indication and a pipeline-flush cancel. The pipeline stalls on `busy` exactly as before; results land in the architectural HI/LO registers held here.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each WIDTH bits, product/accumulator 2·WIDTH.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; clock clk.
- `start`  in  1  issue strobe; qualifies every op except MFHI/MFLO.
- `op`  in  4  operation code (package enum, below).
- `src_a`  in  WIDTH  rs operand / dividend / MTHI-MTLO data.
- `src_b`  in  WIDTH  rt operand / divisor.
- `cancel`  in  1  flush; aborts an in-flight op.
- `res`  out  WIDTH  MFHI/MFLO read data; reset 0.
- `busy`  out  1  op in flight; reset 0.
- `div_zero`  out  1  one-cycle pulse on DIV/DIVU with src_b==0; reset 0.

## Operation
- Ops: NOP, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO.
- FSM states: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE + start + MUL/DIV/MADD/MSUB op, divisor nonzero: latch operand magnitudes, signs and op; load counter = WIDTH; go to CALC.
- CALC: one bit per cycle; multiply shifts multiplier right and adds multiplicand into upper accumulator; divide shifts remainder left and does a trial subtract, setting the quotient bit when non-negative. Counter decrements; at 1 go to FIX.
- FIX: apply sign correction, then write HI/LO and go to IDLE.
  - Signed multiply: negate the 2W product when signs differ.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign. MIN_INT / −1 gives LO = MIN_INT, HI = 0.
  - MADD/MSUB: {HI,LO} ± product, modulo 2^(2·WIDTH). MADD/MSUB signed, MADDU/MSUBU unsigned.
  - MULT/DIV: HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
- IDLE + start + MTHI/MTLO: HI or LO ← src_a at that edge; no busy.
- IDLE + start + DIV/DIVU with src_b==0: HI/LO unchanged; no busy; `div_zero` high in the following cycle only.
- start while busy: ignored; the op in flight continues.
- cancel while busy: next edge → IDLE; HI/LO unchanged. cancel has priority over the FIX write. cancel in IDLE has no effect and does not suppress a same-cycle start.
- `res` = HI for MFHI, LO for MFLO, only when start==0 and busy==0; otherwise 0.
- reset in any state: IDLE, HI = LO = 0, counter 0, div_zero 0.

## Timing
- Start sampled at edge E0.
- busy high from after E0 for WIDTH+1 cycles: WIDTH CALC cycles plus one FIX cycle.
- HI/LO are updated at the edge ending FIX, the same edge at which busy falls.
- MFHI/MFLO in the first non-busy cycle sees the new value (33 stall cycles for WIDTH=32).
- `res` is combinational from HI/LO/op/start/busy.
- `div_zero` is registered.

## Structure
- Shared package `md_pkg`: op enum (4-bit), FSM state enum, helper function `md_is_signed(op)`.
- One natural sub-module, `md_iter_core`:
  - Holds the CALC datapath: accumulator/remainder shift register, counter, add/subtract.
  - Top level keeps the FSM, sign handling, HI/LO and read mux.

## Test plan (WIDTH=32)
- MULT src_a=0xFFFFFFFF, src_b=2 → busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MFHI/MFLO return these.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 5, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=6, LO=0. Then MSUB 1×1 → HI=5, LO=0xFFFFFFFF.
- DIV 9/0 with HI=LO=0x1234 → busy never high, div_zero high exactly one cycle, HI/LO stay 0x1234.
- MULTU 3×4 with cancel at CALC cycle 10 → busy low next cycle, HI/LO unchanged. Restart is accepted in the following cycle and gives LO=12.
- Reset asserted mid-DIVU, and start pulsed while busy → busy=0, HI=LO=0, res=0 after reset. The start issued while busy does not alter the in-flight result.
